// File: rtl/piso_pkg.sv
// piso_pkg: shared types for the parallel-in/serial-out transmitter.
//   piso_state_e : frame FSM states. PARITY is only reachable when the design
//                  is built with PISO_PARITY_EN defined.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: data-bit position counter for one serial frame.
//   clk    in  : rising-edge clock
//   rst_n  in  : asynchronous active-low reset, clears the count
//   load   in  : restart the count at 0 (a new word was accepted)
//   en     in  : advance by one; holds at WIDTH-1 and never wraps
//   count  out : current bit position, $clog2(WIDTH) bits
//   last   out : count has reached WIDTH-1
module piso_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     en,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  assign last = (count == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake and sends it one bit
// per clock, framed by ser_valid and ser_last. Words stream back-to-back when
// the next one is offered during the final frame cycle.
//
// Parameters:
//   WIDTH      data bits per word (>= 2)
//   LSB_FIRST  1: bit 0 goes out first; 0: bit WIDTH-1 goes out first
// Ports:
//   clk         in  : rising-edge clock
//   rst_n       in  : asynchronous active-low reset
//   load_valid  in  : load_data is valid
//   load_ready  out : a word can be accepted this cycle (decoded from state)
//   load_data   in  : word to serialize
//   ser_out     out : serial data bit (registered)
//   ser_valid   out : ser_out carries a frame bit (registered)
//   ser_last    out : final bit of the frame (registered)
// Build option:
//   PISO_PARITY_EN : append one even-parity bit to every frame; ser_last and
//                    the back-to-back load slot move to that parity cycle.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  piso_state_e      state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0]    count;
  logic             cnt_last;
  logic             cnt_en;
  logic             accept;
  logic             ser_out_n, ser_valid_n, ser_last_n;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  // Bit that goes on the wire for a given shift-register value.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction

  // Shift-register contents after one bit has been sent.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (cnt_en),
    .count (count),
    .last  (cnt_last)
  );

`ifdef PISO_PARITY_EN
  assign load_ready = (state == IDLE) || (state == PARITY);
`else
  assign load_ready = (state == IDLE) || ((state == SHIFT) && cnt_last);
`endif

  assign accept = load_valid && load_ready;

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_en  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          sr_n    = load_data;
        end
      end
      SHIFT: begin
        if (!cnt_last) begin
          cnt_en = 1'b1;
          sr_n   = advance(sr);
        end else begin
`ifdef PISO_PARITY_EN
          state_n = PARITY;
`else
          if (accept) begin
            sr_n = load_data;
          end else begin
            state_n = IDLE;
          end
`endif
        end
      end
      PARITY: begin
        if (accept) begin
          state_n = SHIFT;
          sr_n    = load_data;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output registers are loaded with what the next state will present, so the
  // pins change on the same edge as the state and carry no input-to-output path.
  always_comb begin
    ser_valid_n = (state_n != IDLE);
    ser_out_n   = 1'b0;
    case (state_n)
      SHIFT:  ser_out_n = head_bit(sr_n);
`ifdef PISO_PARITY_EN
      PARITY: ser_out_n = par;
`endif
      default: ser_out_n = 1'b0;
    endcase
`ifdef PISO_PARITY_EN
    ser_last_n = (state_n == PARITY);
`else
    // Entering the last data bit: still shifting and the counter is one short.
    ser_last_n = (state == SHIFT) && !cnt_last && (count == PRE_LAST);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      ser_out   <= ser_out_n;
      ser_valid <= ser_valid_n;
      ser_last  <= ser_last_n;
    end
  end

`ifdef PISO_PARITY_EN
  // Parity of the word is captured at load so the word itself can shift away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^load_data;
    end
  end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: self-checking bench for piso_serializer (WIDTH=8).
// Two instances share all inputs: one LSB-first, one MSB-first. A queue model
// holds the bits still to be sent for each instance; hand-written frame tables
// and corner-case sequences are checked alongside it.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = W;
  localparam bit PAR = 1'b0;
`endif

  logic         clk, rst_n, load_valid;
  logic [W-1:0] load_data;
  logic         rdy_l, out_l, vld_l, last_l;
  logic         rdy_m, out_m, vld_m, last_m;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_l),
    .load_data(load_data), .ser_out(out_l), .ser_valid(vld_l), .ser_last(last_l)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_m),
    .load_data(load_data), .ser_out(out_m), .ser_valid(vld_m), .ser_last(last_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit q_l[$];
  bit q_m[$];

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] seq_l;  // bit i = i-th bit on the wire, LSB-first instance
    logic [W-1:0] seq_m;  // bit i = i-th bit on the wire, MSB-first instance
    logic         par;
  } vec_t;
  vec_t tbl[9];

  int vc, nl, lp1, lp2, nr, rp, g;
  bit dropped, drop;

  task automatic chk(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", name, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, exp);
    end
  endtask

  function automatic void push_frame(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      q_l.push_back(d[i]);
      q_m.push_back(d[W-1-i]);
    end
    if (PAR) begin
      q_l.push_back(^d);
      q_m.push_back(^d);
    end
  endfunction

  task automatic check_model();
    chk("lsb_valid", vld_l, q_l.size() > 0);
    chk("lsb_out",   out_l, (q_l.size() > 0) ? q_l[0] : 1'b0);
    chk("lsb_last",  last_l, q_l.size() == 1);
    chk("msb_valid", vld_m, q_m.size() > 0);
    chk("msb_out",   out_m, (q_m.size() > 0) ? q_m[0] : 1'b0);
    chk("msb_last",  last_m, q_m.size() == 1);
    if (rst_n) begin
      chk("lsb_ready", rdy_l, q_l.size() <= 1);
      chk("msb_ready", rdy_m, q_m.size() <= 1);
    end
  endtask

  // One clock: update the model at the rising edge from the inputs presented
  // there, then compare at the falling edge.
  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = rst_n && load_valid && (q_l.size() <= 1);
    if (!rst_n) begin
      q_l.delete();
      q_m.delete();
    end else begin
      if (q_l.size() > 0) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
      if (acc) push_frame(load_data);
    end
    @(negedge clk);
    cyc++;
    check_model();
  endtask

  initial begin
    tbl[0] = '{8'h0F, 8'h0F, 8'hF0, 1'b0};
    tbl[1] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
    tbl[2] = '{8'h01, 8'h01, 8'h80, 1'b1};
    tbl[3] = '{8'h80, 8'h80, 8'h01, 1'b1};
    tbl[4] = '{8'h36, 8'h36, 8'h6C, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tbl[7] = '{8'h07, 8'h07, 8'hE0, 1'b1};
    tbl[8] = '{8'h03, 8'h03, 8'hC0, 1'b0};

    rst_n      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid_l", vld_l, 1'b0);
    chk("rst_out_l",   out_l, 1'b0);
    chk("rst_last_l",  last_l, 1'b0);
    chk("rst_valid_m", vld_m, 1'b0);
    chk("rst_out_m",   out_m, 1'b0);
    chk("rst_last_m",  last_m, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_ready_l", rdy_l, 1'b1);
    chk("rel_ready_m", rdy_m, 1'b1);

    // Single frames from IDLE against hand-computed bit sequences.
    foreach (tbl[k]) begin
      load_data  = tbl[k].data;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < FL; i++) begin
        if (i < W) begin
          chk("tbl_bit_l", out_l, tbl[k].seq_l[i]);
          chk("tbl_bit_m", out_m, tbl[k].seq_m[i]);
        end else begin
          chk("tbl_par_l", out_l, tbl[k].par);
          chk("tbl_par_m", out_m, tbl[k].par);
        end
        chk("tbl_last", last_l, i == FL - 1);
        tick();
      end
      chk("tbl_idle_valid", vld_l, 1'b0);
      chk("tbl_idle_out",   out_m, 1'b0);
    end

    // Back-to-back: load_valid held across two words.
    load_data  = 8'h0F;
    load_valid = 1'b1;
    tick();
    load_data = 8'hF0;
    vc = 0; nl = 0; lp1 = 0; lp2 = 0; nr = 0; rp = 0; g = 0; dropped = 1'b0;
    while (vld_l && g < 40) begin
      vc++;
      g++;
      if (last_l) begin
        nl++;
        if (nl == 1) lp1 = vc; else lp2 = vc;
      end
      if (rdy_l) begin
        nr++;
        if (nr == 1) rp = vc;
      end
      drop = rdy_l && !dropped;
      tick();
      if (drop) begin
        load_valid = 1'b0;
        dropped    = 1'b1;
      end
    end
    load_valid = 1'b0;
    chk_int("b2b_valid_run", vc, 2 * FL);
    chk_int("b2b_last_cnt",  nl, 2);
    chk_int("b2b_last1_pos", lp1, FL);
    chk_int("b2b_last2_pos", lp2, 2 * FL);
    chk_int("b2b_ready_pos", rp, FL);
    chk_int("b2b_ready_cnt", nr, 2);
    tick();

    // Words offered while busy are ignored.
    load_data  = 8'h00;
    load_valid = 1'b1;
    tick();
    for (int i = 1; i <= FL; i++) begin
      if (i >= 2 && i <= 6) begin
        load_valid = 1'b1;
        load_data  = 8'hFF;
        chk("busy_ready", rdy_l, 1'b0);
      end else begin
        load_valid = 1'b0;
      end
      chk("busy_bit_l", out_l, 1'b0);
      chk("busy_bit_m", out_m, 1'b0);
      tick();
    end
    load_valid = 1'b0;
    chk("busy_done_valid", vld_l, 1'b0);

    // Reset in the middle of a frame.
    load_data  = 8'h0F;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    q_l.delete();
    q_m.delete();
    chk("midrst_valid_l", vld_l, 1'b0);
    chk("midrst_out_l",   out_l, 1'b0);
    chk("midrst_last_l",  last_l, 1'b0);
    chk("midrst_valid_m", vld_m, 1'b0);
    chk("midrst_last_m",  last_m, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_ready", rdy_l, 1'b1);
    load_data  = 8'h0F;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("midrst_first_l", out_l, 1'b1);
    chk("midrst_first_m", out_m, 1'b0);
    repeat (FL + 1) tick();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 500; i++) begin
      load_data  = W'($urandom);
      load_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    load_valid = 1'b0;
    repeat (FL + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
